// File: rtl/bus_ctrl_pkg.sv
// Shared types and constants for the bus transfer controller and its arbiter.
package bus_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StLatch,
    StDone,
    StErr
  } state_e;

  localparam int unsigned NREG_DEF = 4;
  localparam int unsigned IW_DEF   = 2;

  // One-hot requester identifiers as they appear on grant vectors.
  localparam logic [1:0] REQ0 = 2'b01;
  localparam logic [1:0] REQ1 = 2'b10;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with an internal last-grant flag; the grant is
// combinational from valid, the flag moves only when advance is asserted.
module rr_arb2
  import bus_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  // 1 means requester 1 was granted last, so requester 0 wins the next tie.
  logic last_q;

  always_comb begin
    grant = 2'b00;
    unique case (valid)
      2'b01:   grant = REQ0;
      2'b10:   grant = REQ1;
      2'b11:   grant = last_q ? REQ0 : REQ1;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      last_q <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Register-to-register transfer sequencer for a shared 8-bit bus: arbitrates two
// requesters and drives one-hot oen/inen strobes. BUS_XFER_BCAST_EN turns req_dst into masks.
module bus_xfer_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned IW   = IW_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*IW-1:0]   req_src,
`ifdef BUS_XFER_BCAST_EN
  input  logic [2*NREG-1:0] req_dst,
`else
  input  logic [2*IW-1:0]   req_dst,
`endif
  output logic [1:0]        gnt,
  output logic [NREG-1:0]   oen,
  output logic [NREG-1:0]   inen,
  output logic              busy,
  output logic              done,
  output logic              err
);

`ifdef BUS_XFER_BCAST_EN
  localparam int unsigned DW = NREG;
`else
  localparam int unsigned DW = IW;
`endif

  state_e        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [IW-1:0] src_q, sel_src;
  logic [DW-1:0] dst_q, sel_dst;
  logic [1:0]    pick;
  logic          handshake;
  logic          bad_req;

  rr_arb2 u_arb (
    .clk     (clk),
    .clr     (clr),
    .valid   (req_valid),
    .advance (handshake),
    .grant   (pick)
  );

  assign req_ready = (state_q == StIdle) ? pick : 2'b00;
  assign handshake = |(req_valid & req_ready);

  assign sel_src = pick[1] ? req_src[IW +: IW] : req_src[0 +: IW];
  assign sel_dst = pick[1] ? req_dst[DW +: DW] : req_dst[0 +: DW];

  always_comb begin
    bad_req = 1'b0;
    if (32'(sel_src) >= NREG) begin
      bad_req = 1'b1;
    end
`ifdef BUS_XFER_BCAST_EN
    if (sel_dst == '0) begin
      bad_req = 1'b1;
    end
    // A mask that includes the source would have a register capture itself.
    for (int i = 0; i < int'(NREG); i++) begin
      if ((sel_src == IW'(i)) && sel_dst[i]) begin
        bad_req = 1'b1;
      end
    end
`else
    if ((32'(sel_dst) >= NREG) || (sel_dst == sel_src)) begin
      bad_req = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          state_d = bad_req ? StErr : StDrive;
          gnt_d   = pick;
        end
      end
      StDrive: state_d = StLatch;
      StLatch: state_d = StDone;
      StDone, StErr: begin
        state_d = StIdle;
        gnt_d   = 2'b00;
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
      gnt_q   <= 2'b00;
      src_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      if (handshake) begin
        src_q <= sel_src;
        dst_q <= sel_dst;
      end
    end
  end

  // Strobes decode only registered state, never the live request inputs.
  always_comb begin
    oen  = '0;
    inen = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      if (((state_q == StDrive) || (state_q == StLatch)) && (src_q == IW'(i))) begin
        oen[i] = 1'b1;
      end
    end
    if (state_q == StLatch) begin
`ifdef BUS_XFER_BCAST_EN
      inen = dst_q;
`else
      for (int i = 0; i < int'(NREG); i++) begin
        if (dst_q == IW'(i)) begin
          inen[i] = 1'b1;
        end
      end
`endif
    end
  end

  assign gnt  = gnt_q;
  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign err  = (state_q == StErr);

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Self-checking bench for bus_xfer_ctrl: vector table, transaction scoreboard and
// directed sequences for ties, mid-transfer reset and sample-once behaviour.
module tb_bus_xfer_ctrl;

  localparam int NREG = 4;
  localparam int IW   = 2;
`ifdef BUS_XFER_BCAST_EN
  localparam int DW = NREG;
  localparam logic [DW-1:0] D_TIE0 = 4'b1000;
  localparam logic [DW-1:0] D_TIE1 = 4'b0100;
  localparam logic [DW-1:0] D_R1   = 4'b0010;
`else
  localparam int DW = IW;
  localparam logic [DW-1:0] D_TIE0 = 2'd3;
  localparam logic [DW-1:0] D_TIE1 = 2'd2;
  localparam logic [DW-1:0] D_R1   = 2'd1;
`endif

  logic              clk;
  logic              clr;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [2*IW-1:0]   req_src;
  logic [2*DW-1:0]   req_dst;
  logic [1:0]        gnt;
  logic [NREG-1:0]   oen;
  logic [NREG-1:0]   inen;
  logic              busy;
  logic              done;
  logic              err;

  bus_xfer_ctrl #(.NREG(NREG), .IW(IW)) dut (
    .clk       (clk),
    .clr       (clr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_src   (req_src),
    .req_dst   (req_dst),
    .gnt       (gnt),
    .oen       (oen),
    .inen      (inen),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [1:0]      gnt;
    logic [NREG-1:0] oen;
    logic [NREG-1:0] inen;
    bit              bad;
  } exp_t;

  exp_t sb[$];
  bit   m_busy = 1'b0;
  bit   m_last = 1'b1;
  int   cyc = 0;

  function automatic logic [1:0] arb(input logic [1:0] v, input bit last);
    case (v)
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
      2'b11:   return last ? 2'b01 : 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic exp_t mk_exp(input logic [1:0] pk, input logic [2*IW-1:0] srcs,
                                  input logic [2*DW-1:0] dsts);
    exp_t e;
    logic [IW-1:0] s;
    logic [DW-1:0] d;
    s = pk[1] ? srcs[IW +: IW] : srcs[0 +: IW];
    d = pk[1] ? dsts[DW +: DW] : dsts[0 +: DW];
    e.gnt = pk;
    e.oen = '0;
    e.inen = '0;
    for (int i = 0; i < NREG; i++) e.oen[i] = (int'(s) == i);
`ifdef BUS_XFER_BCAST_EN
    e.bad = (int'(s) >= NREG) || (d == '0) || ((int'(s) < NREG) && d[s]);
    e.inen = d;
`else
    e.bad = (int'(s) >= NREG) || (int'(d) >= NREG) || (s == d);
    for (int i = 0; i < NREG; i++) e.inen[i] = (int'(d) == i);
`endif
    return e;
  endfunction

  always @(negedge clk) begin
    logic [1:0] pk;
    exp_t e;
    if (clr) begin
      sb.delete();
      m_busy = 1'b0;
      m_last = 1'b1;
      cyc = 0;
    end else if (!m_busy) begin
      pk = arb(req_valid, m_last);
      chk("idle_ready", req_ready, pk);
      chk("idle_strobes", {oen, inen}, 0);
      chk("idle_flags", {gnt, busy, done, err}, 0);
      if (pk != 2'b00) begin
        sb.push_back(mk_exp(pk, req_src, req_dst));
        m_last = pk[1];
        m_busy = 1'b1;
        cyc = 0;
      end
    end else begin
      cyc++;
      e = sb[0];
      chk("busy_ready", req_ready, 0);
      chk("busy_flag", busy, 1);
      chk("held_gnt", gnt, e.gnt);
      if (e.bad) begin
        chk("err_cycle", {oen, inen, done, err}, 1);
        void'(sb.pop_front());
        m_busy = 1'b0;
      end else begin
        case (cyc)
          1: chk("drive_cycle", {oen, inen, done, err}, {e.oen, {NREG{1'b0}}, 2'b00});
          2: chk("latch_cycle", {oen, inen, done, err}, {e.oen, e.inen, 2'b00});
          3: begin
            chk("done_cycle", {oen, inen, done, err}, 2'b10);
            void'(sb.pop_front());
            m_busy = 1'b0;
          end
          default: begin
            chk("xfer_overrun", cyc, 3);
            void'(sb.pop_front());
            m_busy = 1'b0;
          end
        endcase
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  typedef struct {
    logic [1:0]    v;
    logic [IW-1:0] s0, s1;
    logic [DW-1:0] d0, d1;
    logic [1:0]    gnt;
    bit            err;
    bit            corrupt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input logic [1:0] v, input logic [IW-1:0] s0,
                               input logic [DW-1:0] d0, input logic [IW-1:0] s1,
                               input logic [DW-1:0] d1, input logic [1:0] g, input bit e,
                               input bit c);
    vec_t r;
    r.v = v; r.s0 = s0; r.d0 = d0; r.s1 = s1; r.d1 = d1;
    r.gnt = g; r.err = e; r.corrupt = c;
    return r;
  endfunction

  task automatic wait_hs(input string name);
    bit hs = 1'b0;
    for (int i = 0; i < 10 && !hs; i++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) hs = 1'b1;
    end
    chk(name, hs, 1);
  endtask

  task automatic run_one(input vec_t t);
    bit fin = 1'b0;
    @(posedge clk); #1;
    req_valid = t.v;
    req_src = {t.s1, t.s0};
    req_dst = {t.d1, t.d0};
    wait_hs("hs_timeout");
    @(posedge clk); #1;
    req_valid = 2'b00;
    if (t.corrupt) req_src = '1;
    for (int i = 0; i < 8 && !fin; i++) begin
      @(negedge clk);
      if (done || err) begin
        fin = 1'b1;
        chk("vec_gnt", gnt, t.gnt);
        chk("vec_err", err, t.err);
      end
    end
    chk("completion_seen", fin, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0] gseq[4];
    int tdone[4];
    int nd;
    bit found;

    clr = 1'b1;
    req_valid = 2'b00;
    req_src = '0;
    req_dst = '0;
    @(negedge clk);
    chk("reset_outs", {req_ready, gnt, oen, inen, busy, done, err}, 0);
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("post_reset_outs", {req_ready, gnt, oen, inen, busy, done, err}, 0);

`ifdef BUS_XFER_BCAST_EN
    vecs.push_back(mkv(2'b01, 2'd0, 4'b1110, 2'd0, 4'b0000, 2'b01, 1'b0, 1'b0));
    vecs.push_back(mkv(2'b10, 2'd0, 4'b0000, 2'd0, 4'b0011, 2'b10, 1'b1, 1'b0));
    vecs.push_back(mkv(2'b01, 2'd2, 4'b0000, 2'd0, 4'b0000, 2'b01, 1'b1, 1'b0));
    vecs.push_back(mkv(2'b11, 2'd1, 4'b0100, 2'd3, 4'b0001, 2'b10, 1'b0, 1'b0));
    vecs.push_back(mkv(2'b01, 2'd0, 4'b0001, 2'd0, 4'b0000, 2'b01, 1'b1, 1'b0));
    vecs.push_back(mkv(2'b01, 2'd0, 4'b0100, 2'd0, 4'b0000, 2'b01, 1'b0, 1'b1));
`else
    vecs.push_back(mkv(2'b01, 2'd2, 2'd0, 2'd0, 2'd0, 2'b01, 1'b0, 1'b0));
    vecs.push_back(mkv(2'b10, 2'd0, 2'd0, 2'd1, 2'd1, 2'b10, 1'b1, 1'b0));
    vecs.push_back(mkv(2'b11, 2'd1, 2'd2, 2'd0, 2'd3, 2'b01, 1'b0, 1'b0));
    vecs.push_back(mkv(2'b01, 2'd3, 2'd1, 2'd0, 2'd0, 2'b01, 1'b0, 1'b0));
    vecs.push_back(mkv(2'b11, 2'd1, 2'd3, 2'd3, 2'd2, 2'b10, 1'b0, 1'b0));
    vecs.push_back(mkv(2'b11, 2'd1, 2'd3, 2'd3, 2'd2, 2'b01, 1'b0, 1'b0));
    vecs.push_back(mkv(2'b01, 2'd0, 2'd0, 2'd0, 2'd0, 2'b01, 1'b1, 1'b0));
    vecs.push_back(mkv(2'b01, 2'd0, 2'd2, 2'd0, 2'd0, 2'b01, 1'b0, 1'b1));
`endif
    foreach (vecs[i]) run_one(vecs[i]);

    // Held tie after reset: grants alternate starting with requester 0.
    @(posedge clk); #1 clr = 1'b1;
    @(negedge clk);
    chk("reset2_outs", {gnt, oen, inen, busy, done, err}, 0);
    @(posedge clk); #1 clr = 1'b0;
    req_valid = 2'b11;
    req_src = {2'd3, 2'd1};
    req_dst = {D_TIE1, D_TIE0};
    nd = 0;
    for (int c = 0; c < 40 && nd < 4; c++) begin
      @(negedge clk);
      if (done) begin
        gseq[nd] = gnt;
        tdone[nd] = c;
        nd++;
      end
    end
    @(posedge clk); #1 req_valid = 2'b00;
    chk("tie_done_count", nd, 4);
    for (int i = 0; i < nd; i++) chk("tie_gnt_order", gseq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    for (int i = 1; i < nd; i++) chk("tie_spacing", tdone[i] - tdone[i-1], 4);

    // Reset in the LATCH cycle: strobes drop at once and the transfer vanishes.
    @(posedge clk); #1;
    req_valid = 2'b01;
    req_src = {2'd0, 2'd3};
    req_dst = {D_R1, D_R1};
    wait_hs("clr_hs_timeout");
    @(posedge clk); #1 req_valid = 2'b00;
    found = 1'b0;
    for (int c = 0; c < 6 && !found; c++) begin
      @(negedge clk);
      if (inen == 4'b0010) found = 1'b1;
    end
    chk("latch_reached", found, 1);
    #2 clr = 1'b1;
    #1;
    chk("clr_async_strobes", {oen, inen}, 0);
    chk("clr_async_gnt", {gnt, busy, done}, 0);
    @(negedge clk);
    @(posedge clk); #1 clr = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("no_done_after_clr", done, 0);
    end
    run_one(mkv(2'b11, 2'd1, D_TIE0, 2'd3, D_TIE1, 2'b01, 1'b0, 1'b0));

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bus_xfer_ctrl.md
Name: bus_xfer_ctrl

Overview:
- Sequencer and arbiter for a shared 8-bit bus connecting NREG bus registers; each register has input-enable (inen) and output-enable (oen) strobes and a shared clr.
- Two requesters each submit register-to-register transfers (src index, dst index).
- Block arbitrates round-robin and drives one-hot oen/inen strobe vectors so exactly one register drives the bus and the destination captures it.
- Sits between the control unit / front panel and the register bank.

Parameters:
- NREG, 4, number of bus registers (2..8).
- IW, 2, index width; must satisfy 2**IW >= NREG.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- clr  in  1  asynchronous active-high reset.
- req_valid  in  2  per-requester transfer request.
- req_ready  out  2  per-requester accept; handshake completes on the clk edge where valid & ready are both 1.
- req_src  in  2*IW  packed source indices; requester r uses bits [r*IW +: IW].
- req_dst  in  2*IW  packed destination indices; same packing as req_src.
- gnt  out  2  one-hot requester currently owning the bus.
- oen  out  NREG  one-hot register output enables.
- inen  out  NREG  one-hot register input enables.
- busy  out  1  transfer in progress (state != IDLE).
- done  out  1  one-cycle pulse when a transfer completes.
- err  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset (clr=1, async):
  - state=IDLE; oen, inen, gnt, req_ready, done, err = 0; busy=0.
  - last_gnt=1, so requester 0 wins the first tie.
- All outputs are registered or decoded from the registered state; no combinational path from req_* to oen/inen.
- States: IDLE, DRIVE, LATCH, DONE, ERR.
- IDLE:
  - req_ready = the arbiter's one-hot pick.
  - Arbitration: if only one req_valid is 1, it wins. If both are 1, the requester != last_gnt wins.
  - On handshake: capture src/dst, set gnt, update last_gnt.
  - Next state is ERR if src==dst, src>=NREG or dst>=NREG; otherwise DRIVE.
- DRIVE (1 cycle): oen[src]=1, inen=0 (bus settle).
- LATCH (1 cycle): oen[src]=1, inen[dst]=1. The destination register captures on the rising edge ending this cycle.
- DONE (1 cycle): oen=0, inen=0, done=1, gnt still held. Next state IDLE.
- ERR (1 cycle): err=1; no strobes ever asserted. Next state IDLE.
- Timing:
  - Latency from handshake edge to done: 3 cycles.
  - Throughput: 1 transfer per 4 cycles. req_ready is 0 outside IDLE, so back-to-back requests wait.
- Invariants:
  - oen and inen are never both non-one-hot.
  - inen is never asserted without oen.
  - inen is high for exactly 1 cycle per transfer.
  - gnt is 0 in IDLE.
- req_src/req_dst are sampled only at the handshake; changes afterwards are ignored.
- clr asserted mid-transfer: strobes drop immediately, no done is produced, and the transfer is lost. last_gnt returns to 1.
- A requester that drops req_valid before ready has no effect.

Optional Feature:
- Macro BUS_XFER_BCAST_EN.
- Defined:
  - req_dst is reinterpreted as a packed per-requester NREG-bit one-hot-or-multi mask; port width becomes 2*NREG.
  - In LATCH, inen equals the mask, so several destinations capture simultaneously.
  - The request is rejected (ERR) if the mask is 0 or the mask includes src.
- Undefined: index behaviour exactly as above.

Decomposition:
- Package bus_ctrl_pkg holds:
  - state enum (IDLE, DRIVE, LATCH, DONE, ERR);
  - default NREG/IW constants;
  - requester ID constants REQ0/REQ1.
- Sub-module rr_arb2:
  - Inputs: clk, clr, valid[1:0], advance.
  - Output: one-hot grant[1:0].
  - Holds last_gnt internally.
  - Reused by later bus masters.

Test Plan:
- Reset: clr=1 at t=0, release after 2 cycles → all outputs 0. Then req_valid=01, src=2, dst=0 → ready[0]=1; oen=0100 for 2 cycles; inen=0001 in the 2nd of those cycles only; done 3 cycles after the handshake.
- Tie: req_valid=11 held, r0 (src1,dst3), r1 (src3,dst2) → grants in order r0, r1, r0, r1; each done separated by 4 cycles.
- Illegal request: r1 src=1, dst=1 → err pulse for 1 cycle, oen=inen=0 throughout, done never asserted, last_gnt=1.
- Reset mid-LATCH: assert clr while inen=0010 → oen/inen/gnt are 0 within the same cycle, no done; next tie grants r0.
- Sample-once check: change req_src from 0 to 3 during DRIVE → oen stays 0001 until DONE.
- With BUS_XFER_BCAST_EN: src=0, mask=1110 → inen=1110 for 1 cycle. Mask=0011 (includes src 0) → err.
